tic_sequencer: RTL and testbench
================================

Name: tic_sequencer

Overview:
- Controller that sequences one TiC-SAT tile (SA + FIFO_in + FIFO_out) through a complete GEMM tile: weight load, input streaming, pipeline drain, and result readout.
- Sits between the host-side word streams (valid/ready) and the tile's tic_in/command/col/tic_out pins.
- Owns all command/col generation, so the tile never receives a beat the host has not supplied.

Parameters:
- CMD_NOP, 2'b00, command code for no operation; the tile holds state.
- CMD_LOAD_W, 2'b01, command code that writes the tic_in word into the weight column selected by col.
- CMD_STREAM, 2'b10, command code that pushes the tic_in word into FIFO_in lane col and advances the array.
- CMD_READ, 2'b11, command code that pops one word from FIFO_out lane col onto tic_out.
- ROWS_W, 8, width of the num_rows field.
- DRAIN_CYCLES, 7, number of zero-data STREAM beats that flush the array after the last input.
- READ_LAT, 1, cycles from a CMD_READ issue until tic_out is valid (range 1..3).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle tile start request
- num_rows  in  ROWS_W  number of input row-vectors in the tile; sampled on an accepted start
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse at tile completion
- in_valid  in  1  host input word valid
- in_data  in  32  host input word: weights, then activations
- in_ready  out  1  controller accepts in_data this cycle
- out_valid  out  1  result word valid
- out_data  out  32  result word
- out_ready  in  1  downstream accepts out_data
- sa_data  out  32  drives tile tic_in
- sa_command  out  2  drives tile command
- sa_col  out  2  drives tile col
- sa_result  in  32  tile tic_out

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sa_command=CMD_NOP, sa_col=0, sa_data=0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, all counters and the skid buffer cleared, in-flight reads discarded.
- All tile-facing outputs are registered. The tile sees a command one cycle after the controller decides it.
- States: IDLE, LOAD_W, STREAM, DRAIN, READ, DONE.
- IDLE: an accepted start latches num_rows and sets busy.
  - num_rows != 0: go to LOAD_W.
  - num_rows == 0: go to DONE; no tile command is ever issued.
- start is ignored while busy=1.
- LOAD_W: in_ready=1.
  - Each in_valid&in_ready beat issues CMD_LOAD_W with sa_data=in_data and sa_col=beat index 0..3.
  - After 4 beats, go to STREAM.
- STREAM: in_ready=1. Each accepted beat issues CMD_STREAM with sa_col cycling 0,1,2,3,0,...
  - num_rows*4 beats in total; after the last beat, go to DRAIN.
- Stall in LOAD_W/STREAM: a cycle with in_valid=0 issues CMD_NOP. sa_col and the beat counter hold.
- DRAIN: in_ready=0. Issues DRAIN_CYCLES consecutive CMD_STREAM beats with sa_data=0; sa_col continues cycling.
  - Never stalls. Then go to READ.
- READ: issues num_rows*4 CMD_READ beats, sa_col cycling 0..3 from 0.
  - Credit rule: a read is issued only when (skid occupancy + reads in flight) < 2.
  - sa_result is captured into the 2-entry skid FIFO exactly READ_LAT cycles after the issue.
  - out_valid = skid non-empty; out_data = skid head. Pop on out_valid&out_ready.
  - Simultaneous capture and pop in the same cycle is allowed; occupancy stays unchanged.
- READ -> DONE: after the last read is issued, the last capture has occurred, and the skid is empty.
- DONE: one cycle; done=1, busy drops in the same cycle, then IDLE.
  - A start in the DONE cycle is ignored.
- Ordering: out_data words leave in issue order. No word is lost or duplicated under any out_ready pattern.
- Counters: beat counter is ROWS_W+2 bits, so num_rows=2^ROWS_W-1 does not wrap.
- Reset mid-tile: the controller aborts with no done pulse. The tile itself is reset by the same reset.

Test Plan:
- Reset, then idle: sa_command=CMD_NOP, busy=0, out_valid=0; start with num_rows=0 -> done pulses 2 cycles after start, with zero non-NOP commands.
- num_rows=1, in_valid always 1, out_ready always 1 -> command trace is 4×LOAD_W (col 0..3), 4×STREAM (col 0..3), 7×STREAM with data 0, then 4×READ (col 0..3). Exactly 4 out beats equal to sa_result, then done.
- num_rows=2 with in_valid toggling 1,0,1,0 -> NOP inserted on every gap; sa_col never skips; total accepted beats = 12.
- num_rows=3, out_ready low for 20 cycles during READ -> at most 2 reads are outstanding, out_data holds stable, and all 12 words are delivered in order once ready returns.
- start pulsed again during STREAM and in the DONE cycle -> ignored; exactly one done per accepted start.
- reset asserted mid-DRAIN -> outputs return to reset values immediately (asynchronously); the next start with num_rows=1 completes normally.

Source files
------------

// File: rtl/tic_sequencer.sv
// Tile controller for one TiC-SAT tile: loads weights, streams activations, drains the
// array and reads results back through a 2-entry skid buffer with credit-based issue.
module tic_sequencer #(
    parameter logic [1:0] CMD_NOP      = 2'b00,
    parameter logic [1:0] CMD_LOAD_W   = 2'b01,
    parameter logic [1:0] CMD_STREAM   = 2'b10,
    parameter logic [1:0] CMD_READ     = 2'b11,
    parameter int unsigned ROWS_W      = 8,
    parameter int unsigned DRAIN_CYCLES = 7,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROWS_W-1:0] num_rows,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic [31:0]       sa_data,
    output logic [1:0]        sa_command,
    output logic [1:0]        sa_col,
    input  logic [31:0]       sa_result
);

    localparam int unsigned BEAT_W = ROWS_W + 2;
    localparam logic [BEAT_W-1:0] ONE        = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] DRAIN_LAST = BEAT_W'(DRAIN_CYCLES - 1);
    localparam logic [3:0] PIPE_MASK = 4'((4'b1 << READ_LAT) - 4'b1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_READ, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [1:0]          sa_col_q, sa_col_d;
    logic [31:0]         sa_data_q, sa_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          pipe_q, pipe_d;
    logic [31:0]         skid_q [2];
    logic [31:0]         skid_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic [BEAT_W-1:0]   total;
    logic [2:0]          inflight;
    logic                credit_ok;
    logic                capture;
    logic                pop;

    assign total      = {rows_q, 2'b00};
    assign capture    = pipe_q[READ_LAT-1];
    assign pop        = (cnt_q != 2'd0) && out_ready;

    // The command register itself counts as an in-flight read: it is on the tile pins now.
    assign inflight   = 3'(cmd_q == CMD_READ) + 3'($countones(pipe_q & PIPE_MASK));
    assign credit_ok  = ({1'b0, cnt_q} + inflight) < 3'd2;

    assign busy       = busy_q;
    assign done       = done_q;
    assign in_ready   = (state_q == S_LOAD_W) || (state_q == S_STREAM);
    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = skid_q[rd_ptr_q];
    assign sa_data    = sa_data_q;
    assign sa_command = cmd_q;
    assign sa_col     = sa_col_q;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        beat_d    = beat_q;
        col_d     = col_q;
        cmd_d     = CMD_NOP;
        sa_col_d  = sa_col_q;
        sa_data_d = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    col_d   = '0;
                    state_d = (num_rows == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (in_valid) begin
                    cmd_d     = CMD_LOAD_W;
                    sa_data_d = in_data;
                    sa_col_d  = col_q;
                    col_d     = col_q + 2'd1;
                    if (beat_q == BEAT_W'(3)) begin
                        beat_d  = '0;
                        state_d = S_STREAM;
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    cmd_d     = CMD_STREAM;
                    sa_data_d = in_data;
                    sa_col_d  = col_q;
                    col_d     = col_q + 2'd1;
                    if (beat_q == total - ONE) begin
                        beat_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                cmd_d    = CMD_STREAM;
                sa_col_d = col_q;
                col_d    = col_q + 2'd1;
                if (beat_q == DRAIN_LAST) begin
                    beat_d  = '0;
                    col_d   = '0;
                    state_d = S_READ;
                end else begin
                    beat_d = beat_q + ONE;
                end
            end
            S_READ: begin
                if (beat_q != total) begin
                    if (credit_ok) begin
                        cmd_d    = CMD_READ;
                        sa_col_d = col_q;
                        col_d    = col_q + 2'd1;
                        beat_d   = beat_q + ONE;
                    end
                end else if (inflight == 3'd0 && cnt_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pipe_d   = {pipe_q[2:0], cmd_q == CMD_READ};
        skid_d   = skid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (capture) begin
            skid_d[wr_ptr_q] = sa_result;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(capture) - 2'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            beat_q    <= '0;
            col_q     <= '0;
            cmd_q     <= CMD_NOP;
            sa_col_q  <= '0;
            sa_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pipe_q    <= '0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            beat_q    <= beat_d;
            col_q     <= col_d;
            cmd_q     <= cmd_d;
            sa_col_q  <= sa_col_d;
            sa_data_q <= sa_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pipe_q    <= pipe_d;
            skid_q    <= skid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tic_sequencer.sv
// Scoreboard bench for tic_sequencer: expected tile commands and result words are queued
// at tile start; a negedge monitor pops and compares them as the DUT produces them.
module tb_tic_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_rows;
    logic        busy, done;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [31:0] sa_data;
    logic [1:0]  sa_command;
    logic [1:0]  sa_col;
    logic [31:0] sa_result;

    always #5 clk = ~clk;

    tic_sequencer #(
        .ROWS_W(8),
        .DRAIN_CYCLES(7),
        .READ_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sa_data(sa_data), .sa_command(sa_command), .sa_col(sa_col),
        .sa_result(sa_result)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [1:0]  col;
        logic [31:0] data;
    } cmd_t;

    cmd_t        cmd_q [$];
    logic [31:0] out_q [$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int non_nop = 0;
    int acc_cnt = 0;
    int reads_issued = 0;
    int pops = 0;
    int unsigned rd_cnt = 0;
    int unsigned rd_base = 0;
    int tile = 0;

    function automatic logic [31:0] mk_word(int unsigned idx, logic [1:0] col);
        return {8'hC5, 6'd0, idx[15:0], col};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Tile stub: FIFO_out returns a word tagged with a running read index and the lane.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_result <= 32'hDEAD_BEEF;
        end else if (sa_command == 2'b11) begin
            sa_result <= mk_word(rd_cnt, sa_col);
            rd_cnt    <= rd_cnt + 1;
        end else begin
            sa_result <= 32'hDEAD_BEEF;
        end
    end

    logic        prev_ir, prev_iv, prev_ov, prev_or;
    logic [31:0] prev_od;

    always @(negedge clk) begin
        if (reset) begin
            prev_ir = 1'b0; prev_iv = 1'b0; prev_ov = 1'b0; prev_or = 1'b1; prev_od = '0;
        end else begin
            if (sa_command != 2'b00) begin
                non_nop++;
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", {30'd0, sa_command}, 32'd0);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    check("cmd", {30'd0, sa_command}, {30'd0, e.cmd});
                    check("col", {30'd0, sa_col}, {30'd0, e.col});
                    if (e.cmd != 2'b11) check("sa_data", sa_data, e.data);
                end
            end
            if (sa_command == 2'b11) begin
                reads_issued++;
                check("outstanding_le2", 32'(reads_issued - pops <= 2), 32'd1);
            end
            if (prev_ir) check("issue_follows_hs", 32'(sa_command != 2'b00), {31'd0, prev_iv});
            if (prev_ov && !prev_or) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_od);
            end
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                pops++;
                if (out_q.size() == 0) check("out_unexpected", out_data, 32'hFFFF_FFFF);
                else check("out_data", out_data, out_q.pop_front());
            end
            if (done) done_cnt++;
            prev_ir = in_ready; prev_iv = in_valid;
            prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
        end
    end

    function automatic logic [31:0] wgt(int i);
        return 32'h1100_0000 | 32'(tile << 8) | 32'(i);
    endfunction

    function automatic logic [31:0] act_w(int k);
        return 32'h2200_0000 | 32'(tile << 12) | 32'(k);
    endfunction

    task automatic push_expected(int rows);
        for (int i = 0; i < 4; i++) cmd_q.push_back('{2'b01, 2'(i), wgt(i)});
        for (int k = 0; k < rows * 4; k++) cmd_q.push_back('{2'b10, 2'(k), act_w(k)});
        for (int d = 0; d < 7; d++) cmd_q.push_back('{2'b10, 2'(d), 32'd0});
        for (int k = 0; k < rows * 4; k++) begin
            cmd_q.push_back('{2'b11, 2'(k), 32'd0});
            out_q.push_back(mk_word(rd_base + k, 2'(k)));
        end
    endtask

    task automatic pulse_start(int rows);
        @(posedge clk); #1;
        start = 1'b1; num_rows = 8'(rows);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_words(int rows, bit toggle);
        bit ok;
        for (int i = 0; i < 4 + rows * 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = (i < 4) ? wgt(i) : act_w(i - 4);
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
            if (toggle) begin @(posedge clk); #1; in_valid = 1'b0; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_tile(int rows, bit toggle, bit stall, bit poke);
        int dc, nn0, ac0, r0;
        bit got;
        tile++;
        push_expected(rows);
        rd_base += 32'(rows * 4);
        dc = done_cnt; nn0 = non_nop; ac0 = acc_cnt; r0 = reads_issued;
        pulse_start(rows);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        fork
            drive_words(rows, toggle);
            if (stall) begin
                for (int c = 0; c < 1000; c++) begin
                    @(negedge clk);
                    if (reads_issued > r0) break;
                end
                @(posedge clk); #1; out_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1; out_ready = 1'b1;
            end
            if (poke) begin
                repeat (8) @(posedge clk);
                #1; start = 1'b1; num_rows = 8'd9;
                repeat (2) @(posedge clk);
                #1; start = 1'b0; num_rows = 8'(rows);
            end
        join
        if (poke) begin
            for (int c = 0; c < 1000; c++) begin
                @(posedge clk); #1;
                if (out_q.size() == 0) break;
            end
            // Hold start only while busy, so the DONE cycle sees it but IDLE never does.
            for (int c = 0; c < 50; c++) begin
                start = busy;
                if (!busy) break;
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt > dc) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        check("one_done", 32'(done_cnt - dc), 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("non_nop_count", 32'(non_nop - nn0), 32'(4 + rows * 8 + 7));
        check("accepted_beats", 32'(acc_cnt - ac0), 32'(4 + rows * 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nn0;
        reset = 1'b1; start = 1'b0; num_rows = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        check("rst_cmd", {30'd0, sa_command}, 32'd0);
        check("rst_col", {30'd0, sa_col}, 32'd0);
        check("rst_data", sa_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_cmd", {30'd0, sa_command}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // num_rows = 0: done two cycles after the start cycle, no tile commands.
        dc = done_cnt; nn0 = non_nop;
        @(posedge clk); #1; start = 1'b1; num_rows = 8'd0;
        @(negedge clk);
        check("z_done_c0", {31'd0, done}, 32'd0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("z_done_c1", {31'd0, done}, 32'd0);
        check("z_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("z_done_c2", {31'd0, done}, 32'd1);
        check("z_busy_c2", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("z_one_done", 32'(done_cnt - dc), 32'd1);
        check("z_no_cmds", 32'(non_nop - nn0), 32'd0);

        run_tile(1, 1'b0, 1'b0, 1'b0);
        run_tile(2, 1'b1, 1'b0, 1'b0);
        run_tile(3, 1'b0, 1'b1, 1'b0);
        run_tile(2, 1'b0, 1'b0, 1'b1);

        // Abort mid-DRAIN with reset, then a clean tile.
        tile++;
        push_expected(1);
        dc = done_cnt;
        pulse_start(1);
        drive_words(1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_drain_cmd", {30'd0, sa_command}, 32'd2);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1; reset = 1'b1;
        #1;
        check("arst_cmd", {30'd0, sa_command}, 32'd0);
        check("arst_col", {30'd0, sa_col}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        cmd_q.delete();
        out_q.delete();
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        run_tile(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
